// File: rtl/screen_arbiter.sv
// Arbiter sharing one single-port screen RAM between the CPU data port and the
// VGA pixel fetcher. Each access has a fixed 3-cycle latency, and the next grant overlaps the access in flight.
module screen_arbiter #(
   parameter int ADDR_WIDTH   = 13,
   parameter int DATA_WIDTH   = 16,
   parameter int VGA_PRIORITY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_write,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_busy,
   input  logic                  vga_req,
   input  logic [ADDR_WIDTH-1:0] vga_address,
   output logic [DATA_WIDTH-1:0] vga_rdata,
   output logic                  vga_ack,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VGA  = 2'd2
   } owner_t;

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   logic                  last_vga_q, last_vga_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                  ram_wren_q, ram_wren_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] vga_rdata_q, vga_rdata_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  vga_ack_q, vga_ack_d;

   logic cpu_elig_s, vga_elig_s;
   logic grant_cpu_s, grant_vga_s;

   // Winner selection; the owner of the access in flight sits out its own CAPTURE slot.
   always_comb begin
      cpu_elig_s  = cpu_req & ~((state_q == S_CAPTURE) && (owner_q == OWN_CPU));
      vga_elig_s  = vga_req & ~((state_q == S_CAPTURE) && (owner_q == OWN_VGA));
      grant_cpu_s = 1'b0;
      grant_vga_s = 1'b0;
      if (cpu_elig_s && vga_elig_s) begin
         if (VGA_PRIORITY != 0) begin
            grant_vga_s = 1'b1;
         end else if (last_vga_q) begin
            grant_cpu_s = 1'b1;
         end else begin
            grant_vga_s = 1'b1;
         end
      end else begin
         grant_cpu_s = cpu_elig_s;
         grant_vga_s = vga_elig_s;
      end
   end

   // Next-state logic: issue on grant, capture read data and pulse the owner's ack.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_vga_d    = last_vga_q;
      wr_d          = wr_q;
      ram_address_d = ram_address_q;
      ram_wdata_d   = ram_wdata_q;
      ram_wren_d    = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      vga_rdata_d   = vga_rdata_q;
      cpu_ack_d     = 1'b0;
      vga_ack_d     = 1'b0;
      case (state_q)
         S_IDLE, S_CAPTURE: begin
            if (state_q == S_CAPTURE) begin
               if (owner_q == OWN_CPU) begin
                  cpu_ack_d = 1'b1;
                  if (!wr_q) begin
                     cpu_rdata_d = ram_rdata;
                  end else begin
                     cpu_rdata_d = cpu_rdata_q;
                  end
               end else if (owner_q == OWN_VGA) begin
                  vga_ack_d   = 1'b1;
                  vga_rdata_d = ram_rdata;
               end else begin
                  cpu_ack_d = 1'b0;
               end
            end else begin
               cpu_ack_d = 1'b0;
            end
            if (grant_cpu_s) begin
               state_d       = S_ISSUE;
               owner_d       = OWN_CPU;
               last_vga_d    = 1'b0;
               wr_d          = cpu_write;
               ram_address_d = cpu_address;
               ram_wdata_d   = cpu_wdata;
               ram_wren_d    = cpu_write;
            end else if (grant_vga_s) begin
               state_d       = S_ISSUE;
               owner_d       = OWN_VGA;
               last_vga_d    = 1'b1;
               wr_d          = 1'b0;
               ram_address_d = vga_address;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_CAPTURE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_NONE;
         last_vga_q    <= 1'b1;
         wr_q          <= 1'b0;
         ram_address_q <= {ADDR_WIDTH{1'b0}};
         ram_wdata_q   <= {DATA_WIDTH{1'b0}};
         ram_wren_q    <= 1'b0;
         cpu_rdata_q   <= {DATA_WIDTH{1'b0}};
         vga_rdata_q   <= {DATA_WIDTH{1'b0}};
         cpu_ack_q     <= 1'b0;
         vga_ack_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_vga_q    <= last_vga_d;
         wr_q          <= wr_d;
         ram_address_q <= ram_address_d;
         ram_wdata_q   <= ram_wdata_d;
         ram_wren_q    <= ram_wren_d;
         cpu_rdata_q   <= cpu_rdata_d;
         vga_rdata_q   <= vga_rdata_d;
         cpu_ack_q     <= cpu_ack_d;
         vga_ack_q     <= vga_ack_d;
      end
   end

   assign ram_address = ram_address_q;
   assign ram_wdata   = ram_wdata_q;
   assign ram_wren    = ram_wren_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign vga_rdata   = vga_rdata_q;
   assign cpu_ack     = cpu_ack_q;
   assign vga_ack     = vga_ack_q;
   assign cpu_busy    = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter: instance a uses VGA priority, instance b
// uses round-robin; each has its own behavioural single-port RAM.
module tb_screen_arbiter;

   logic        clk;
   logic        reset;

   logic        cpu_req_a, cpu_write_a, vga_req_a;
   logic [12:0] cpu_address_a, vga_address_a, ram_address_a;
   logic [15:0] cpu_wdata_a, cpu_rdata_a, vga_rdata_a, ram_wdata_a, ram_rdata_a;
   logic        cpu_ack_a, cpu_busy_a, vga_ack_a, ram_wren_a;

   logic        cpu_req_b, cpu_write_b, vga_req_b;
   logic [12:0] cpu_address_b, vga_address_b, ram_address_b;
   logic [15:0] cpu_wdata_b, cpu_rdata_b, vga_rdata_b, ram_wdata_b, ram_rdata_b;
   logic        cpu_ack_b, cpu_busy_b, vga_ack_b, ram_wren_b;

   logic [15:0] mem_a [0:8191];
   logic [15:0] mem_b [0:8191];

   int tests_run;
   int tests_failed;

   screen_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .VGA_PRIORITY(1)) dut_a (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req_a), .cpu_write(cpu_write_a), .cpu_address(cpu_address_a),
      .cpu_wdata(cpu_wdata_a), .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a), .cpu_busy(cpu_busy_a),
      .vga_req(vga_req_a), .vga_address(vga_address_a), .vga_rdata(vga_rdata_a), .vga_ack(vga_ack_a),
      .ram_address(ram_address_a), .ram_wdata(ram_wdata_a), .ram_wren(ram_wren_a), .ram_rdata(ram_rdata_a)
   );

   screen_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .VGA_PRIORITY(0)) dut_b (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req_b), .cpu_write(cpu_write_b), .cpu_address(cpu_address_b),
      .cpu_wdata(cpu_wdata_b), .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b), .cpu_busy(cpu_busy_b),
      .vga_req(vga_req_b), .vga_address(vga_address_b), .vga_rdata(vga_rdata_b), .vga_ack(vga_ack_b),
      .ram_address(ram_address_b), .ram_wdata(ram_wdata_b), .ram_wren(ram_wren_b), .ram_rdata(ram_rdata_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wren_a) mem_a[ram_address_a] <= ram_wdata_a;
      ram_rdata_a <= mem_a[ram_address_a];
   end

   always @(posedge clk) begin
      if (ram_wren_b) mem_b[ram_address_b] <= ram_wdata_b;
      ram_rdata_b <= mem_b[ram_address_b];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain CPU write on instance a, bounded wait for the ack.
   task automatic cpu_write_plain(input logic [12:0] addr, input logic [15:0] data);
      bit seen;
      seen = 1'b0;
      cpu_req_a = 1'b1; cpu_write_a = 1'b1; cpu_address_a = addr; cpu_wdata_a = data;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cpu_ack_a === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      cpu_req_a = 1'b0; cpu_write_a = 1'b0;
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL preload_ack: no cpu_ack within 10 cycles for addr %h", addr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tests_run++;
      if ({cpu_ack_a, vga_ack_a, ram_wren_a, cpu_busy_a} !== 4'b0000 ||
          ram_address_a !== 13'h0000 || cpu_rdata_a !== 16'h0000 || vga_rdata_a !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_outputs: acks/wren/busy=%b addr=%h crd=%h vrd=%h, want all zero",
                  {cpu_ack_a, vga_ack_a, ram_wren_a, cpu_busy_a}, ram_address_a, cpu_rdata_a, vga_rdata_a);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_cpu_write();
      cpu_req_a = 1'b1; cpu_write_a = 1'b1; cpu_address_a = 13'h1FFF; cpu_wdata_a = 16'h1234;
      tick();
      tests_run++;
      if (ram_wren_a !== 1'b1 || ram_address_a !== 13'h1FFF || ram_wdata_a !== 16'h1234) begin
         tests_failed++;
         $display("FAIL write_issue: wren=%b addr=%h wdata=%h, want 1 1fff 1234", ram_wren_a, ram_address_a, ram_wdata_a);
      end
      tick();
      tests_run++;
      if (ram_wren_a !== 1'b0 || cpu_ack_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_n2: wren=%b ack=%b, want 0 0", ram_wren_a, cpu_ack_a);
      end
      tick();
      tests_run++;
      if (cpu_ack_a !== 1'b1 || ram_wren_a !== 1'b0 || cpu_rdata_a !== 16'h0000) begin
         tests_failed++;
         $display("FAIL write_ack: ack=%b wren=%b rdata=%h, want 1 0 0000", cpu_ack_a, ram_wren_a, cpu_rdata_a);
      end
      cpu_req_a = 1'b0; cpu_write_a = 1'b0;
      tick();
      tests_run++;
      if (cpu_ack_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_ack_pulse: ack=%b, want 0", cpu_ack_a);
      end
      // read back the last word
      cpu_req_a = 1'b1; cpu_address_a = 13'h1FFF;
      tick(); tick(); tick();
      tests_run++;
      if (cpu_ack_a !== 1'b1 || cpu_rdata_a !== 16'h1234) begin
         tests_failed++;
         $display("FAIL write_readback: ack=%b rdata=%h, want 1 1234", cpu_ack_a, cpu_rdata_a);
      end
      cpu_req_a = 1'b0;
      tick();
   endtask

   task automatic test_cpu_read();
      cpu_write_plain(13'h0010, 16'hBEEF);
      tick();
      cpu_req_a = 1'b1; cpu_write_a = 1'b0; cpu_address_a = 13'h0010;
      #1;
      tests_run++;
      if (cpu_busy_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_busy_n: busy=%b, want 1", cpu_busy_a);
      end
      tick();
      tests_run++;
      if (ram_address_a !== 13'h0010 || ram_wren_a !== 1'b0 || cpu_busy_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_issue: addr=%h wren=%b busy=%b, want 0010 0 1", ram_address_a, ram_wren_a, cpu_busy_a);
      end
      tick();
      tests_run++;
      if (cpu_ack_a !== 1'b0 || cpu_busy_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_n2: ack=%b busy=%b, want 0 1", cpu_ack_a, cpu_busy_a);
      end
      tick();
      tests_run++;
      if (cpu_ack_a !== 1'b1 || cpu_rdata_a !== 16'hBEEF || cpu_busy_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_ack: ack=%b rdata=%h busy=%b, want 1 beef 0", cpu_ack_a, cpu_rdata_a, cpu_busy_a);
      end
      cpu_req_a = 1'b0;
      tick();
      tests_run++;
      if (cpu_rdata_a !== 16'hBEEF || cpu_ack_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_hold: rdata=%h ack=%b, want beef 0", cpu_rdata_a, cpu_ack_a);
      end
   endtask

   task automatic test_tie_priority();
      cpu_write_plain(13'h0000, 16'hAAAA);
      tick();
      cpu_write_plain(13'h0001, 16'h5555);
      tick();
      cpu_req_a = 1'b1; cpu_write_a = 1'b0; cpu_address_a = 13'h0001;
      vga_req_a = 1'b1; vga_address_a = 13'h0000;
      tick();
      tests_run++;
      if (ram_address_a !== 13'h0000) begin
         tests_failed++;
         $display("FAIL tie_vga_first: ram_address=%h, want 0000", ram_address_a);
      end
      tick();
      tick();
      tests_run++;
      if (vga_ack_a !== 1'b1 || vga_rdata_a !== 16'hAAAA || cpu_ack_a !== 1'b0 || ram_address_a !== 13'h0001) begin
         tests_failed++;
         $display("FAIL tie_n3: vack=%b vrd=%h cack=%b addr=%h, want 1 aaaa 0 0001",
                  vga_ack_a, vga_rdata_a, cpu_ack_a, ram_address_a);
      end
      vga_req_a = 1'b0;
      tick();
      tick();
      tests_run++;
      if (cpu_ack_a !== 1'b1 || cpu_rdata_a !== 16'h5555 || vga_ack_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_n5: cack=%b crd=%h vack=%b, want 1 5555 0", cpu_ack_a, cpu_rdata_a, vga_ack_a);
      end
      cpu_req_a = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [12:0] exp_addr;
      bit exp_cack, exp_vack;
      int j, k;
      cpu_req_b = 1'b1; cpu_write_b = 1'b0; cpu_address_b = 13'h0100;
      vga_req_b = 1'b1; vga_address_b = 13'h0200;
      for (int t = 1; t <= 16; t++) begin
         tick();
         if (t % 2 == 1) begin
            j = (t - 1) / 2;
            exp_addr = (j % 2 == 0) ? 13'(32'h100 + j / 2) : 13'(32'h200 + j / 2);
            tests_run++;
            if (ram_address_b !== exp_addr || ram_wren_b !== 1'b0) begin
               tests_failed++;
               $display("FAIL rr_grant t=%0d: addr=%h wren=%b, want %h 0", t, ram_address_b, ram_wren_b, exp_addr);
            end
         end
         k = (t - 3) / 2;
         exp_cack = (t >= 3) && (t % 2 == 1) && (k % 2 == 0);
         exp_vack = (t >= 3) && (t % 2 == 1) && (k % 2 == 1);
         tests_run++;
         if (cpu_ack_b !== exp_cack || vga_ack_b !== exp_vack) begin
            tests_failed++;
            $display("FAIL rr_ack t=%0d: cack=%b vack=%b, want %b %b", t, cpu_ack_b, vga_ack_b, exp_cack, exp_vack);
         end
         if (exp_cack) cpu_address_b = cpu_address_b + 13'd1;
         if (exp_vack) vga_address_b = vga_address_b + 13'd1;
      end
      cpu_req_b = 1'b0; vga_req_b = 1'b0;
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_reset_mid_write();
      bit ack_seen;
      ack_seen = 1'b0;
      cpu_req_a = 1'b1; cpu_write_a = 1'b1; cpu_address_a = 13'h0020; cpu_wdata_a = 16'h7777;
      tick();
      tests_run++;
      if (ram_wren_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_issue: wren=%b, want 1", ram_wren_a);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (ram_wren_a !== 1'b0 || cpu_ack_a !== 1'b0 || ram_address_a !== 13'h0000) begin
         tests_failed++;
         $display("FAIL rst_mid_clear: wren=%b ack=%b addr=%h, want 0 0 0000", ram_wren_a, cpu_ack_a, ram_address_a);
      end
      cpu_req_a = 1'b0; cpu_write_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cpu_ack_a !== 1'b0) ack_seen = 1'b1;
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cpu_ack_a !== 1'b0) ack_seen = 1'b1;
      end
      tests_run++;
      if (ack_seen) begin
         tests_failed++;
         $display("FAIL rst_mid_noack: cpu_ack seen=1, want 0");
      end
      cpu_req_a = 1'b1; cpu_address_a = 13'h0010;
      tick(); tick(); tick();
      tests_run++;
      if (cpu_ack_a !== 1'b1 || cpu_rdata_a !== 16'hBEEF) begin
         tests_failed++;
         $display("FAIL rst_after_read: ack=%b rdata=%h, want 1 beef", cpu_ack_a, cpu_rdata_a);
      end
      cpu_req_a = 1'b0;
      tick();
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ram_wren_a !== 1'b0 || cpu_ack_a !== 1'b0 || vga_ack_a !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
      end
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      clk = 1'b0; reset = 1'b1;
      cpu_req_a = 1'b0; cpu_write_a = 1'b0; cpu_address_a = 13'h0; cpu_wdata_a = 16'h0;
      vga_req_a = 1'b0; vga_address_a = 13'h0;
      cpu_req_b = 1'b0; cpu_write_b = 1'b0; cpu_address_b = 13'h0; cpu_wdata_b = 16'h0;
      vga_req_b = 1'b0; vga_address_b = 13'h0;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_tie_priority();
      test_round_robin();
      test_reset_mid_write();
      test_idle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/screen_arbiter.md
Name: screen_arbiter

Overview:
Arbitrates one single-port screen RAM (SPRAM-style, 1-cycle registered read) between two requesters: the CPU data port and the VGA pixel fetcher. Sits inside the memory subsystem, between the screen address decode and the screen RAM. Gives the VGA fetcher its display deadline and stalls the CPU through `cpu_busy`. Fixed 3-cycle access latency; one access may be in flight while the next is granted.

Parameters:
ADDR_WIDTH, 13, screen word address width (8192 words, 512x256 1bpp).
DATA_WIDTH, 16, word width.
VGA_PRIORITY, 1, 1 = VGA wins ties; 0 = round-robin (tie goes to the requester not granted last).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_write  in  1  1 = write, 0 = read; qualified by cpu_req
cpu_address  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  CPU read data, valid with cpu_ack, held until next cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_busy  out  1  = cpu_req & ~cpu_ack (combinational stall)
vga_req  in  1  VGA read request, held until vga_ack
vga_address  in  ADDR_WIDTH  VGA word address
vga_rdata  out  DATA_WIDTH  VGA read data, valid with vga_ack, held until next vga_ack
vga_ack  out  1  one-cycle completion pulse
ram_address  out  ADDR_WIDTH  RAM address (registered)
ram_wdata  out  DATA_WIDTH  RAM write data (registered)
ram_wren  out  1  RAM write enable (registered)
ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset (async): all outputs 0, FSM = IDLE, last_owner = VGA, owner = none.
- FSM states:
  - IDLE: arbitration slot.
  - ISSUE: RAM samples the registered address, data and wren.
  - CAPTURE: ram_rdata valid, latched; also an arbitration slot.
- Arbitration (IDLE or CAPTURE):
  - Eligible requesters: those with req high, excluding the current owner while in CAPTURE (its access is in flight).
  - Single eligible requester: it is granted.
  - Both eligible: VGA if VGA_PRIORITY=1, else the one ≠ last_owner.
  - On grant: register ram_address/ram_wdata/ram_wren from the winner; set owner and last_owner; next state ISSUE.
  - No grant: next state IDLE; ram_wren ← 0.
- ISSUE → CAPTURE unconditionally.
- ram_wren high for exactly one cycle (the ISSUE cycle) per CPU write. Never high for VGA.
- Timing: request sampled in cycle N (IDLE/CAPTURE):
  - N+1: ram_* driven (ISSUE).
  - N+2: CAPTURE; ram_rdata registered into the owner's rdata.
  - N+3: owner's ack high for one cycle.
  - Writes follow the same timing. cpu_rdata is not updated on writes.
- Throughput: one grant per 2 cycles. Two active requesters alternate strictly, so neither starves.
- Requester rules:
  - Hold req, address and wdata stable until ack.
  - A req still high in the cycle after ack is a new request.
  - Dropping req before ack is illegal: the access completes and the ack is still issued.
- Arbitration and ack pulses are independent. An ack at N+3 can coincide with an ISSUE of the other requester's access.
- Reset mid-access: everything clears asynchronously. An in-flight access produces no ack. ram_wren drops immediately, so a write in ISSUE may or may not land.
- No address checking: the full ADDR_WIDTH range is passed through; 0x1FFF is the last word.

Test Plan:
- CPU read alone: RAM[0x0010]=0xBEEF, cpu_req/read at N.
  - ram_address=0x0010 at N+1.
  - cpu_ack and cpu_rdata=0xBEEF at N+3.
  - cpu_busy high N..N+2, low N+3.
- CPU write: address 0x1FFF, wdata 0x1234 at N.
  - ram_wren=1 only at N+1; cpu_ack at N+3.
  - Subsequent read returns 0x1234.
- Tie, VGA_PRIORITY=1: both req at N, VGA addr 0x0000 (=0xAAAA), CPU addr 0x0001 (=0x5555).
  - VGA granted at N, CPU granted at N+2.
  - vga_ack/0xAAAA at N+3; cpu_ack/0x5555 at N+5.
- Round-robin (VGA_PRIORITY=0), both reqs held with new addresses after each ack:
  - Grants alternate CPU, VGA, CPU… (first is CPU, since last_owner=VGA after reset).
  - One ack every 2 cycles; neither requester waits more than 4 cycles.
- Reset asserted at N+1 of a CPU write:
  - ram_wren, acks and busy-related state clear immediately.
  - No cpu_ack issued.
  - After release, a fresh CPU read completes normally in 3 cycles.
- Idle: no reqs for 20 cycles → ram_wren=0, no acks, FSM stays IDLE.
